// File: rtl/coh_pkg.sv
// Shared coherence types for the cache controllers and the snoop bus arbiter.
// Holds the bus function codes, line states, arbiter states and 2-core vectors.
package coh_pkg;

    typedef enum logic [1:0] {
        P_READ  = 2'b00,
        P_WRITE = 2'b01,
        B_READ  = 2'b10,
        B_WRITE = 2'b11
    } func_e;

    typedef enum logic [1:0] {
        INVL = 2'b00,
        SHRD = 2'b01,
        EXCL = 2'b10
    } stat_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SNOOP = 2'b01,
        MEM   = 2'b10,
        DONE  = 2'b11
    } arb_state_e;

    typedef logic [1:0] core_vec_t;

    // Bus functions are the two codes with the upper bit set.
    function automatic logic is_bus_func(input logic [1:0] f);
        return f[1];
    endfunction

endpackage

// File: rtl/snoop_bus_arbiter_if.sv
// Core-side, snoop-side and memory-side signals of the shared snoop bus.
// master = arbiter, slave = controllers, target caches and memory.
interface snoop_bus_arbiter_if #(
    parameter int ADDR_W = 8
);
    import coh_pkg::*;

    core_vec_t         req;
    logic [1:0]        func0;
    logic [1:0]        func1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    core_vec_t         gnt;
    core_vec_t         mem_ready;
    core_vec_t         snoop_ready;
    core_vec_t         snoop_hit;
    core_vec_t         snp_valid;
    logic [ADDR_W-1:0] snp_addr;
    core_vec_t         snp_hit_in;
    core_vec_t         snp_done_in;
    logic              bus_mem_req;
    logic              bus_mem_we;
    logic [ADDR_W-1:0] bus_mem_addr;
    logic              bus_mem_ack;

    modport master (
        input  req, func0, func1, addr0, addr1, snp_hit_in, snp_done_in, bus_mem_ack,
        output gnt, mem_ready, snoop_ready, snoop_hit, snp_valid, snp_addr,
               bus_mem_req, bus_mem_we, bus_mem_addr
    );

    modport slave (
        output req, func0, func1, addr0, addr1, snp_hit_in, snp_done_in, bus_mem_ack,
        input  gnt, mem_ready, snoop_ready, snoop_hit, snp_valid, snp_addr,
               bus_mem_req, bus_mem_we, bus_mem_addr
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way arbiter: sole requester wins, a tie goes to the preferred core; preference moves on upd.
// Latency: combinational grant. Backpressure: none, the caller samples gnt only when it can take an owner.
// Build option ARB_FIXED_PRIO_EN: core0 always wins ties and no preference state exists.
module rr_arb2
    import coh_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  core_vec_t req,
    input  logic      upd,
    input  logic      upd_owner,
    output core_vec_t gnt
);

    logic prio;

`ifdef ARB_FIXED_PRIO_EN
    logic unused_rr;
    assign prio      = 1'b0;
    assign unused_rr = ^{clk, reset, upd, upd_owner};
`else
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prio <= 1'b0;
        end else if (upd) begin
            prio <= ~upd_owner;
        end
    end
`endif

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = prio ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/snoop_bus_arbiter.sv
// Shared-bus arbiter: grants one core, snoops the other core's cache, falls back to memory on miss/timeout.
// Latency: grant→ready = snoop/ack wait + 2 cycles, one IDLE cycle between transactions, all outputs registered.
// Backpressure: a single outstanding transaction; other requests wait in IDLE. ARB_FIXED_PRIO_EN fixes core0 priority.
module snoop_bus_arbiter
    import coh_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int SNP_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    snoop_bus_arbiter_if.master  bus
);

    localparam logic [7:0] TO_LAST = 8'(SNP_TIMEOUT - 1);

    arb_state_e        state, state_nxt;
    logic              owner, owner_nxt;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic [7:0]        cnt, cnt_nxt;
    core_vec_t         elig, arb_gnt;
    core_vec_t         gnt_nxt, mrdy_nxt, srdy_nxt, shit_nxt, sval_nxt;
    logic [ADDR_W-1:0] saddr_nxt, maddr_nxt, sel_addr;
    logic [1:0]        sel_func;
    logic              mreq_nxt, mwe_nxt, upd, other;

    assign other    = ~owner;
    assign elig     = bus.req & {is_bus_func(bus.func1), is_bus_func(bus.func0)};
    assign sel_addr = arb_gnt[1] ? bus.addr1 : bus.addr0;
    assign sel_func = arb_gnt[1] ? bus.func1 : bus.func0;

    rr_arb2 u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (elig),
        .upd       (upd),
        .upd_owner (owner),
        .gnt       (arb_gnt)
    );

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        addr_nxt  = addr_q;
        cnt_nxt   = cnt;
        gnt_nxt   = bus.gnt;
        mrdy_nxt  = 2'b00;
        srdy_nxt  = 2'b00;
        shit_nxt  = bus.snoop_hit;
        sval_nxt  = bus.snp_valid;
        saddr_nxt = bus.snp_addr;
        mreq_nxt  = bus.bus_mem_req;
        mwe_nxt   = bus.bus_mem_we;
        maddr_nxt = bus.bus_mem_addr;
        upd       = 1'b0;
        case (state)
            IDLE: begin
                if (|arb_gnt) begin
                    owner_nxt           = arb_gnt[1];
                    addr_nxt            = sel_addr;
                    gnt_nxt             = arb_gnt;
                    shit_nxt[arb_gnt[1]] = 1'b0;
                    cnt_nxt             = 8'd0;
                    if (sel_func == B_WRITE) begin
                        state_nxt = MEM;
                        mreq_nxt  = 1'b1;
                        mwe_nxt   = 1'b1;
                        maddr_nxt = sel_addr;
                    end else begin
                        state_nxt = SNOOP;
                        sval_nxt  = arb_gnt[1] ? 2'b01 : 2'b10;
                        saddr_nxt = sel_addr;
                    end
                end
            end
            SNOOP: begin
                cnt_nxt = cnt + 8'd1;
                // A response in the timeout cycle still counts as a response.
                if (bus.snp_done_in[other] || cnt == TO_LAST) begin
                    sval_nxt  = 2'b00;
                    saddr_nxt = '0;
                    if (bus.snp_done_in[other] && bus.snp_hit_in[other]) begin
                        state_nxt       = DONE;
                        shit_nxt[owner] = 1'b1;
                        srdy_nxt[owner] = 1'b1;
                        gnt_nxt         = 2'b00;
                    end else begin
                        state_nxt = MEM;
                        mreq_nxt  = 1'b1;
                        mwe_nxt   = 1'b0;
                        maddr_nxt = addr_q;
                    end
                end
            end
            MEM: begin
                if (bus.bus_mem_ack) begin
                    state_nxt       = DONE;
                    mreq_nxt        = 1'b0;
                    mwe_nxt         = 1'b0;
                    maddr_nxt       = '0;
                    mrdy_nxt[owner] = 1'b1;
                    gnt_nxt         = 2'b00;
                end
            end
            DONE: begin
                upd       = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner            <= 1'b0;
            addr_q           <= '0;
            cnt              <= 8'd0;
            bus.gnt          <= 2'b00;
            bus.mem_ready    <= 2'b00;
            bus.snoop_ready  <= 2'b00;
            bus.snoop_hit    <= 2'b00;
            bus.snp_valid    <= 2'b00;
            bus.snp_addr     <= '0;
            bus.bus_mem_req  <= 1'b0;
            bus.bus_mem_we   <= 1'b0;
            bus.bus_mem_addr <= '0;
        end else begin
            owner            <= owner_nxt;
            addr_q           <= addr_nxt;
            cnt              <= cnt_nxt;
            bus.gnt          <= gnt_nxt;
            bus.mem_ready    <= mrdy_nxt;
            bus.snoop_ready  <= srdy_nxt;
            bus.snoop_hit    <= shit_nxt;
            bus.snp_valid    <= sval_nxt;
            bus.snp_addr     <= saddr_nxt;
            bus.bus_mem_req  <= mreq_nxt;
            bus.bus_mem_we   <= mwe_nxt;
            bus.bus_mem_addr <= maddr_nxt;
        end
    end

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Bench for snoop_bus_arbiter: directed plus random transactions checked against a transaction-level model.
// Honours ARB_FIXED_PRIO_EN for the expected tie-break winner.
module tb_snoop_bus_arbiter;

    localparam int TO = 15;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    // Model state: which core wins a tie, and each core's sticky snoop-hit flag.
    int         prio = 0;
    logic [1:0] exp_hit = 2'b00;

    snoop_bus_arbiter_if #(.ADDR_W(8)) bus ();

    snoop_bus_arbiter #(.ADDR_W(8), .SNP_TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"}, 32'(bus.gnt), 0);
        chk({tag, "_rdy"}, 32'({bus.mem_ready, bus.snoop_ready}), 0);
        chk({tag, "_hit"}, 32'(bus.snoop_hit), 0);
        chk({tag, "_snp"}, 32'({bus.snp_valid, bus.snp_addr}), 0);
        chk({tag, "_mem"}, 32'({bus.bus_mem_req, bus.bus_mem_we, bus.bus_mem_addr}), 0);
    endtask

    // d: snoop cycle index at which the target answers (>= TO means never); m: mem cycle of the ack.
    task automatic run_txn(input logic [1:0] rq, input logic [1:0] f0, input logic [1:0] f1,
                           input logic [7:0] a0, input logic [7:0] a1, input int d,
                           input bit hit, input int m, input bit drop);
        logic [1:0] elig, one_w, one_o;
        logic [7:0] a;
        int         w;
        bit         is_wr, hit_path;
        bus.req = rq; bus.func0 = f0; bus.func1 = f1; bus.addr0 = a0; bus.addr1 = a1;
        bus.snp_done_in = 2'b00; bus.snp_hit_in = 2'b00; bus.bus_mem_ack = 1'b0;
        elig = rq & {f1[1], f0[1]};
        tick();
        if (elig == 2'b00) begin
            chk("no_grant", 32'(bus.gnt), 0);
            bus.req = 2'b00;
            return;
        end
        w        = (elig == 2'b11) ? prio : (elig[1] ? 1 : 0);
        one_w    = 2'b01 << w;
        one_o    = 2'b10 >> w;
        a        = (w == 1) ? a1 : a0;
        is_wr    = ((w == 1) ? f1 : f0) == 2'b11;
        hit_path = !is_wr && (d < TO) && hit;
        exp_hit[w] = 1'b0;
        chk("grant", 32'(bus.gnt), 32'(one_w));
        chk("hit_clr", 32'(bus.snoop_hit), 32'(exp_hit));
        if (drop) bus.req[w] = 1'b0;
        if (!is_wr) begin
            for (int i = 0; i < TO; i++) begin
                chk("snp_valid", 32'(bus.snp_valid), 32'(one_o));
                chk("snp_addr", 32'(bus.snp_addr), 32'(a));
                chk("snp_nomem", 32'({bus.bus_mem_req, bus.mem_ready, bus.snoop_ready}), 0);
                bus.bus_mem_ack = 1'($urandom_range(0, 1));
                if (i == d) begin
                    bus.snp_done_in = one_o;
                    bus.snp_hit_in  = hit ? one_o : 2'b00;
                end
                tick();
                bus.snp_done_in = 2'b00; bus.snp_hit_in = 2'b00; bus.bus_mem_ack = 1'b0;
                if (i == d) break;
            end
        end
        if (!hit_path) begin
            for (int j = 0; j <= m; j++) begin
                chk("mem_req", 32'(bus.bus_mem_req), 1);
                chk("mem_we", 32'(bus.bus_mem_we), 32'(is_wr));
                chk("mem_addr", 32'(bus.bus_mem_addr), 32'(a));
                chk("mem_nosnp", 32'({bus.snp_valid, bus.mem_ready, bus.snoop_ready}), 0);
                chk("mem_gnt", 32'(bus.gnt), 32'(one_w));
                bus.snp_done_in = 2'($urandom_range(0, 3));
                bus.snp_hit_in  = 2'($urandom_range(0, 3));
                if (j == m) bus.bus_mem_ack = 1'b1;
                tick();
                bus.snp_done_in = 2'b00; bus.snp_hit_in = 2'b00; bus.bus_mem_ack = 1'b0;
            end
        end
        if (hit_path) exp_hit[w] = 1'b1;
        chk("snoop_ready", 32'(bus.snoop_ready), hit_path ? 32'(one_w) : 0);
        chk("mem_ready", 32'(bus.mem_ready), hit_path ? 0 : 32'(one_w));
        chk("done_gnt", 32'(bus.gnt), 0);
        chk("done_hit", 32'(bus.snoop_hit), 32'(exp_hit));
        chk("done_quiet", 32'({bus.snp_valid, bus.bus_mem_req}), 0);
        tick();
        chk("pulse_end", 32'({bus.mem_ready, bus.snoop_ready}), 0);
        chk("idle_gnt", 32'(bus.gnt), 0);
`ifndef ARB_FIXED_PRIO_EN
        prio = 1 - w;
`endif
    endtask

    initial begin
        int d, m;
        reset = 1'b0;
        bus.req = 2'b00; bus.func0 = 2'b00; bus.func1 = 2'b00;
        bus.addr0 = 8'h00; bus.addr1 = 8'h00;
        bus.snp_hit_in = 2'b00; bus.snp_done_in = 2'b00; bus.bus_mem_ack = 1'b0;
        tick(); tick();
        chk_all_zero("reset");
        reset = 1'b1;
        tick();
        chk_all_zero("post_reset");

        // Directed scenarios
        run_txn(2'b01, 2'b10, 2'b00, 8'h3C, 8'h11, 2, 1'b1, 0, 1'b0);
        run_txn(2'b10, 2'b00, 2'b10, 8'h22, 8'h7E, 1, 1'b0, 3, 1'b0);
        run_txn(2'b01, 2'b11, 2'b00, 8'hA5, 8'h00, 0, 1'b0, 4, 1'b0);
        for (int k = 0; k < 4; k++)
            run_txn(2'b11, 2'b10, 2'b10, 8'h40 + 8'(k), 8'h80 + 8'(k), 1, 1'b1, 0, 1'b0);
        run_txn(2'b01, 2'b10, 2'b00, 8'h5B, 8'h00, 99, 1'b1, 1, 1'b0);
        run_txn(2'b10, 2'b00, 2'b10, 8'h00, 8'h6C, TO - 1, 1'b1, 0, 1'b0);
        run_txn(2'b01, 2'b10, 2'b00, 8'h6D, 8'h00, TO - 1, 1'b0, 2, 1'b1);
        run_txn(2'b11, 2'b01, 2'b00, 8'h01, 8'h02, 0, 1'b0, 0, 1'b0);

        // Random transactions
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 9))
                0, 1:    d = TO - 1;
                2, 3:    d = TO + int'($urandom_range(0, 3));
                default: d = int'($urandom_range(0, TO - 2));
            endcase
            m = int'($urandom_range(0, 4));
            run_txn(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    8'($urandom), 8'($urandom), d, 1'($urandom_range(0, 1)), m,
                    1'($urandom_range(0, 1)));
        end

        // Reset while the memory path is busy
        bus.req = 2'b01; bus.func0 = 2'b11; bus.addr0 = 8'h5A;
        tick();
        chk("rst_mem_req", 32'({bus.bus_mem_req, bus.bus_mem_we, bus.bus_mem_addr}), 32'h3_5A);
        #2 reset = 1'b0;
        #1 chk_all_zero("async_rst");
        bus.req = 2'b00;
        tick();
        reset = 1'b1;
        exp_hit = 2'b00;
        prio    = 0;
        bus.bus_mem_ack = 1'b1;
        tick();
        bus.bus_mem_ack = 1'b0;
        tick();
        chk_all_zero("late_ack");

        // Preference must be back at core0 after reset
        run_txn(2'b11, 2'b10, 2'b10, 8'h91, 8'h92, 3, 1'b1, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/snoop_bus_arbiter.md
Name: snoop_bus_arbiter

Overview:
Shared-bus stage directly downstream of the two per-core cache_controller instances. It arbitrates their bus requests (b_read / b_write), forwards each b_read as a snoop to the other core's cache, and falls back to main memory on a snoop miss or timeout. It returns the mem_ready / snoop_ready / snoop_hit handshakes that the cache controllers consume. It holds a single outstanding transaction at a time.

Parameters:
ADDR_W, 8, width of block address carried on the bus
SNP_TIMEOUT, 15, cycles to wait for snp_done before treating a snoop as a miss (1..255)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-low reset
req  in  2  per-core bus request (bit i = core i: mem_cs | snoop_out of that controller)
func0  in  2  core0 bus function (2'b10 b_read, 2'b11 b_write; others ignored)
func1  in  2  core1 bus function
addr0  in  ADDR_W  core0 block address
addr1  in  ADDR_W  core1 block address
gnt  out  2  one-hot current bus owner
mem_ready  out  2  per-core one-cycle completion pulse, memory path
snoop_ready  out  2  per-core one-cycle completion pulse, snoop path
snoop_hit  out  2  per-core registered snoop-hit flag
snp_valid  out  2  snoop request to core i's cache (target = non-owner)
snp_addr  out  ADDR_W  snooped address
snp_hit_in  in  2  per-core snoop hit from the target cache
snp_done_in  in  2  per-core snoop response valid from the target cache
bus_mem_req  out  1  memory request
bus_mem_we  out  1  1 = write-back, 0 = fill read
bus_mem_addr  out  ADDR_W  memory address
bus_mem_ack  in  1  memory completion

Behaviour:
- Reset (reset=0, async): state IDLE, rr pointer = core0 priority, timeout counter 0. All outputs 0: gnt, mem_ready, snoop_ready, snoop_hit, snp_valid, snp_addr, bus_mem_*.
- FSM states: IDLE, SNOOP, MEM, DONE. All outputs are registered.
- IDLE:
  - A request from a core whose func is not b_read/b_write is ignored.
  - Otherwise pick among asserted req bits: sole requester wins; on a tie the rr pointer wins.
  - Latch owner, func and addr. Set gnt to the owner. Clear snoop_hit[owner].
  - func b_read -> SNOOP. func b_write -> MEM with we=1.
- SNOOP:
  - snp_valid[other] = 1, snp_addr = latched addr. The counter increments every cycle.
  - snp_done_in[other] && snp_hit_in[other] -> set snoop_hit[owner] = 1, go to DONE.
  - snp_done_in[other] && !snp_hit_in[other] -> MEM with we=0.
  - counter == SNP_TIMEOUT-1 with no done -> MEM with we=0.
  - A done arriving in the same cycle as the timeout takes precedence over the timeout.
- MEM:
  - bus_mem_req = 1, bus_mem_we and bus_mem_addr held stable until ack. bus_mem_ack -> DONE.
  - There is no memory timeout.
- DONE: exactly one cycle.
  - Pulse snoop_ready[owner] if the path was a snoop hit; otherwise pulse mem_ready[owner].
  - Drop gnt and snp_valid. Point rr at the non-owner. Go to IDLE.
- snoop_hit[owner] holds from DONE until that core's next grant, so the controller's S3 mem_cs masking stays coherent.
- Latency:
  - Snoop hit: grant→ready = snoop response cycles + 2.
  - Memory path: mem ack cycles + 2.
  - Minimum request-to-request gap is 1 IDLE cycle.
- Boundaries:
  - An owner dropping req mid-transaction does not abort; the transaction completes and the ready pulse is still issued.
  - Ack/done inputs arriving outside the matching state are ignored.
  - Never both mem_ready and snoop_ready in the same cycle.
  - gnt is always one-hot or zero.
  - Reset mid-transaction returns to IDLE immediately and clears all pulses.

Optional Feature:
ARB_FIXED_PRIO_EN
- Defined: core0 always wins simultaneous requests; the rr pointer is not instantiated.
- Undefined (default): round-robin as above.

Decomposition:
- Package coh_pkg holds:
  - func encodings p_read/p_write/b_read/b_write
  - stat encodings excl/shrd/invl
  - arbiter state enum
  - shared typedef for 2-core one-hot vectors
- One sub-module: rr_arb2 (2-input round-robin/fixed arbiter with grant-update strobe).

Test Plan:
- Core0 req, func=b_read, addr=8'h3C; core1 snp_done/snp_hit=1 after 2 cycles -> snp_valid[1]=1 with snp_addr=8'h3C, snoop_hit[0]=1, one snoop_ready[0] pulse, no bus_mem_req.
- Core1 b_read, snoop miss -> bus_mem_req=1 with we=0, addr latched; ack after 3 cycles -> mem_ready[1] pulse, snoop_hit[1]=0.
- Core0 b_write addr=8'hA5 -> no snoop, bus_mem_we=1 and addr=8'hA5 until ack, then mem_ready[0] pulse.
- Both req asserted continuously -> grants alternate 0,1,0,1 (with ARB_FIXED_PRIO_EN: always 0).
- Snoop target never responds -> MEM entered after exactly SNP_TIMEOUT=15 SNOOP cycles; done coincident with timeout -> done wins.
- reset pulsed low in MEM -> all outputs 0 asynchronously, IDLE after release; late bus_mem_ack ignored.
